// File: rtl/mips_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// mips_pkg : control-word bit positions and MEM-stage FSM encoding
// Rev 1.0
// ---------------------------------------------------------------------------
package mips_pkg;

  // MEMReg = {Branch, MemRead, MemWrite, ByteOp}
  localparam int MEM_BRANCH  = 3;
  localparam int MEM_READ    = 2;
  localparam int MEM_WRITE   = 1;
  localparam int MEM_BYTE    = 0;

  // WBReg = {RegWrite, MemToReg}
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } mem_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// mem_lane_align : byte-lane enables, store replication and load extraction
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_lane_align (
  input  logic [1:0]  addr_lo,
  input  logic        byte_op,
  input  logic [31:0] store_data,
  input  logic [31:0] load_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [7:0] load_byte;

  always_comb begin
    load_byte = 8'h00;
    be        = 4'hF;
    wdata     = store_data;
    rdata     = load_data;

    // Little-endian lanes: address offset 0 is bits [7:0].
    case (addr_lo)
      2'd0:    load_byte = load_data[7:0];
      2'd1:    load_byte = load_data[15:8];
      2'd2:    load_byte = load_data[23:16];
      default: load_byte = load_data[31:24];
    endcase

    if (byte_op) begin
      be    = 4'b0001 << addr_lo;
      wdata = {4{store_data[7:0]}};
      rdata = {24'h000000, load_byte};
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// mem_stage : MIPS memory stage - branch resolve, req/ack data bus with
//             timeout, single-cycle IO, MEM/WB register and halt state
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCPlus4PlusOffReg,
  input  logic [31:0] ResultReg,
  input  logic [31:0] OutBReg,
  input  logic        EqualReg,
  input  logic        IOInstReg,
  input  logic        HaltReg,
  input  logic [4:0]  WrRegReg,
  input  logic [3:0]  MEMReg,
  input  logic [1:0]  WBReg,
  output logic        PCSrc,
  output logic [31:0] BranchTarget,
  output logic        MemStall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  input  logic [31:0] io_in,
  output logic [31:0] io_out,
  output logic        io_wr,
  output logic [31:0] ReadDataW,
  output logic [31:0] ResultW,
  output logic [4:0]  WrRegW,
  output logic [1:0]  WBW,
  output logic        Halted,
  output logic        BusErr,
  output logic        AlignErr
);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;
  logic             align_err_q, align_err_d;
  logic             io_wr_q, io_wr_d;
  logic [31:0]      io_out_q, io_out_d;
  logic [31:0]      read_data_q, read_data_d;
  logic [31:0]      result_q, result_d;
  logic [4:0]       wr_reg_q, wr_reg_d;
  logic [1:0]       wb_q, wb_d;

  logic        is_rd, is_wr, byte_op, branch;
  logic        mem_op, io_op, misaligned;
  logic        st_idle, st_wait, st_halted;
  logic        req, abandon, stall;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_rdata;

  assign is_rd   = MEMReg[MEM_READ];
  assign is_wr   = MEMReg[MEM_WRITE];
  assign byte_op = MEMReg[MEM_BYTE];
  assign branch  = MEMReg[MEM_BRANCH];

  assign mem_op     = (is_rd | is_wr) & ~IOInstReg;
  assign io_op      = IOInstReg & (is_rd | is_wr);
  assign misaligned = mem_op & ~byte_op & (ResultReg[1:0] != 2'b00);

  assign st_idle   = (state_q == IDLE);
  assign st_wait   = (state_q == WAIT);
  assign st_halted = (state_q == HALTED);

  // Gating with reset drops the request the moment reset asserts, even
  // though EX/MEM may still present the memory op.
  assign req     = reset & ((st_idle & mem_op & ~misaligned) | st_wait);
  assign abandon = st_wait & ~dmem_ack & (cnt_q == CNT_W'(TIMEOUT));
  assign stall   = (req & ~dmem_ack & ~abandon) | st_halted;

  mem_lane_align u_lane (
    .addr_lo    (ResultReg[1:0]),
    .byte_op    (byte_op),
    .store_data (OutBReg),
    .load_data  (dmem_rdata),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .rdata      (lane_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bus_err_d = bus_err_q;
    case (state_q)
      IDLE: begin
        if (req && !dmem_ack) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(1);
        end else if (HaltReg) begin
          state_d = HALTED;
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (abandon) begin
          state_d   = IDLE;
          cnt_d     = '0;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    result_d    = result_q;
    wr_reg_d    = wr_reg_q;
    read_data_d = read_data_q;
    wb_d        = 2'b00;
    io_out_d    = io_out_q;
    io_wr_d     = 1'b0;
    align_err_d = st_idle & misaligned;

    if (st_idle && io_op && is_wr) begin
      io_out_d = OutBReg;
      io_wr_d  = 1'b1;
    end

    // Stalled edges hold the payload; abandoned/misaligned ones advance as a bubble.
    if (!stall) begin
      result_d    = ResultReg;
      wr_reg_d    = WrRegReg;
      read_data_d = io_op ? io_in : lane_rdata;
      if (!abandon && !misaligned) begin
        wb_d = {WBReg[WB_REGWRITE], WBReg[WB_MEMTOREG]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bus_err_q   <= 1'b0;
      align_err_q <= 1'b0;
      io_wr_q     <= 1'b0;
      io_out_q    <= 32'h0;
      read_data_q <= 32'h0;
      result_q    <= 32'h0;
      wr_reg_q    <= 5'h0;
      wb_q        <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_err_q   <= bus_err_d;
      align_err_q <= align_err_d;
      io_wr_q     <= io_wr_d;
      io_out_q    <= io_out_d;
      read_data_q <= read_data_d;
      result_q    <= result_d;
      wr_reg_q    <= wr_reg_d;
      wb_q        <= wb_d;
    end
  end

  assign PCSrc        = branch & EqualReg & ~st_halted;
  assign BranchTarget = PCPlus4PlusOffReg;
  assign MemStall     = stall;
  assign dmem_req     = req;
  assign dmem_we      = req & is_wr;
  assign dmem_addr    = ResultReg;
  assign dmem_wdata   = lane_wdata;
  assign dmem_be      = lane_be;
  assign io_out       = io_out_q;
  assign io_wr        = io_wr_q;
  assign ReadDataW    = read_data_q;
  assign ResultW      = result_q;
  assign WrRegW       = wr_reg_q;
  assign WBW          = wb_q;
  assign Halted       = st_halted;
  assign BusErr       = bus_err_q;
  assign AlignErr     = align_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_stage : randomized self-checking bench for mem_stage
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_stage;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] PCPlus4PlusOffReg, ResultReg, OutBReg;
  logic        EqualReg, IOInstReg, HaltReg;
  logic [4:0]  WrRegReg;
  logic [3:0]  MEMReg;
  logic [1:0]  WBReg;
  logic        PCSrc;
  logic [31:0] BranchTarget;
  logic        MemStall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [31:0] io_in, io_out;
  logic        io_wr;
  logic [31:0] ReadDataW, ResultW;
  logic [4:0]  WrRegW;
  logic [1:0]  WBW;
  logic        Halted, BusErr, AlignErr;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .PCPlus4PlusOffReg(PCPlus4PlusOffReg), .ResultReg(ResultReg), .OutBReg(OutBReg),
    .EqualReg(EqualReg), .IOInstReg(IOInstReg), .HaltReg(HaltReg),
    .WrRegReg(WrRegReg), .MEMReg(MEMReg), .WBReg(WBReg),
    .PCSrc(PCSrc), .BranchTarget(BranchTarget), .MemStall(MemStall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .io_in(io_in), .io_out(io_out), .io_wr(io_wr),
    .ReadDataW(ReadDataW), .ResultW(ResultW), .WrRegW(WrRegW), .WBW(WBW),
    .Halted(Halted), .BusErr(BusErr), .AlignErr(AlignErr)
  );

  always #5 clk = ~clk;

  // Reference model: byte lanes from address arithmetic.
  function automatic logic [3:0] model_be(input logic bop, input logic [31:0] a);
    int lane;
    lane = int'(a % 32'd4);
    if (!bop) return 4'hF;
    return 4'(2 ** lane);
  endfunction

  function automatic logic [31:0] model_load(input logic bop, input logic [31:0] a, input logic [31:0] d);
    int lane;
    lane = int'(a % 32'd4);
    if (!bop) return d;
    return (d >> (8 * lane)) & 32'hFF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic bop, input logic [31:0] w);
    if (!bop) return w;
    return (w % 32'd256) * 32'h01010101;
  endfunction

  task automatic nop();
    PCPlus4PlusOffReg = 32'h0; ResultReg = 32'h0; OutBReg = 32'h0;
    EqualReg = 1'b0; IOInstReg = 1'b0; HaltReg = 1'b0;
    WrRegReg = 5'h0; MEMReg = 4'h0; WBReg = 2'b00;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Presents one access and plays the memory with an ack in cycle 'delay'
  // (negative = never). Returns at posedge+1 after the completing edge.
  task automatic run_access(input logic rd, input logic wr, input logic bop,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input logic [1:0] wb, input int delay,
                            output int reqc, output int stallc, output int wb_bad,
                            output logic [3:0] be0, output logic we0,
                            output logic [31:0] wd0, output logic [31:0] addr0,
                            output logic [4:0] wreg, output logic done);
    reqc = 0; stallc = 0; wb_bad = 0; done = 1'b0;
    be0 = 4'h0; we0 = 1'b0; wd0 = 32'h0; addr0 = 32'h0;
    wreg = 5'($urandom);
    IOInstReg = 1'b0; HaltReg = 1'b0; EqualReg = 1'b0;
    MEMReg = {1'b0, rd, wr, bop}; ResultReg = addr; OutBReg = wdata;
    WBReg = wb; WrRegReg = wreg;
    for (int k = 0; k <= TIMEOUT + 2 && !done; k++) begin
      dmem_ack   = (k == delay);
      dmem_rdata = (k == delay) ? rdata : $urandom;
      @(negedge clk);
      if (k == 0) begin
        be0 = dmem_be; we0 = dmem_we; wd0 = dmem_wdata; addr0 = dmem_addr;
      end
      if (dmem_req) reqc++;
      if (MemStall) stallc++;
      if (k > 0 && WBW !== 2'b00) wb_bad++;
      done = !MemStall;
      step();
    end
    dmem_ack = 1'b0;
    nop();
  endtask

  task automatic test_reset();
    nop(); dmem_ack = 1'b0; dmem_rdata = 32'h0; io_in = 32'h0; reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if ({ReadDataW, ResultW} !== 64'h0) begin n_fail++; $display("FAIL reset_wb_data: got %h %h expected 0", ReadDataW, ResultW); end
    n_checks++; if ({WrRegW, WBW} !== 7'h0) begin n_fail++; $display("FAIL reset_wb_ctl: got %h %h expected 0", WrRegW, WBW); end
    n_checks++; if ({io_out, io_wr} !== 33'h0) begin n_fail++; $display("FAIL reset_io: got %h %b expected 0", io_out, io_wr); end
    n_checks++; if ({Halted, BusErr, AlignErr} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {Halted, BusErr, AlignErr}); end
    n_checks++; if ({dmem_req, MemStall} !== 2'b00) begin n_fail++; $display("FAIL reset_bus: got %b expected 00", {dmem_req, MemStall}); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_word_store();
    int reqc, stallc, wb_bad; logic [3:0] be0; logic we0, done;
    logic [31:0] wd0, addr0; logic [4:0] wreg;
    run_access(1'b0, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 32'h0, 2'b00, 3,
               reqc, stallc, wb_bad, be0, we0, wd0, addr0, wreg, done);
    n_checks++; if (reqc !== 4) begin n_fail++; $display("FAIL store_req_cycles: got %0d expected 4", reqc); end
    n_checks++; if (stallc !== 3) begin n_fail++; $display("FAIL store_stall_cycles: got %0d expected 3", stallc); end
    n_checks++; if (be0 !== 4'hF || we0 !== 1'b1) begin n_fail++; $display("FAIL store_be_we: got %h %b expected f 1", be0, we0); end
    n_checks++; if (wd0 !== 32'hDEADBEEF || addr0 !== 32'h40) begin n_fail++; $display("FAIL store_bus: got %h @%h expected deadbeef @40", wd0, addr0); end
    n_checks++; if (wb_bad !== 0) begin n_fail++; $display("FAIL store_bubble: got %0d nonzero WBW cycles expected 0", wb_bad); end
    n_checks++; if (ResultW !== 32'h40) begin n_fail++; $display("FAIL store_resultw: got %h expected 40", ResultW); end
  endtask

  task automatic test_byte_load();
    int reqc, stallc, wb_bad; logic [3:0] be0; logic we0, done;
    logic [31:0] wd0, addr0, a, d; logic [4:0] wreg;
    for (int i = 0; i < 5; i++) begin
      a = (i == 0) ? 32'h43 : $urandom;
      d = (i == 0) ? 32'hAABBCCDD : $urandom;
      run_access(1'b1, 1'b0, 1'b1, a, 32'h0, d, 2'b11, 0,
                 reqc, stallc, wb_bad, be0, we0, wd0, addr0, wreg, done);
      n_checks++; if (reqc !== 1 || stallc !== 0) begin n_fail++; $display("FAIL bload_timing[%0d]: got req %0d stall %0d expected 1 0", i, reqc, stallc); end
      n_checks++; if (be0 !== model_be(1'b1, a)) begin n_fail++; $display("FAIL bload_be[%0d]: got %h expected %h", i, be0, model_be(1'b1, a)); end
      n_checks++; if (ReadDataW !== model_load(1'b1, a, d)) begin n_fail++; $display("FAIL bload_data[%0d]: got %h expected %h", i, ReadDataW, model_load(1'b1, a, d)); end
      n_checks++; if (WBW !== 2'b11 || WrRegW !== wreg) begin n_fail++; $display("FAIL bload_wb[%0d]: got %b r%0d expected 11 r%0d", i, WBW, WrRegW, wreg); end
    end
  endtask

  task automatic test_random_traffic();
    int reqc, stallc, wb_bad, delay; logic [3:0] be0; logic we0, done, rd, bop;
    logic [31:0] wd0, addr0, a, d, w; logic [4:0] wreg; logic [1:0] wb;
    for (int i = 0; i < 16; i++) begin
      rd = 1'($urandom); bop = 1'($urandom);
      a = $urandom; if (!bop) a = a & ~32'h3;
      d = $urandom; w = $urandom; wb = 2'($urandom);
      delay = $urandom_range(0, 6);
      run_access(rd, ~rd, bop, a, w, d, wb, delay,
                 reqc, stallc, wb_bad, be0, we0, wd0, addr0, wreg, done);
      n_checks++; if (reqc !== delay + 1 || stallc !== delay) begin n_fail++; $display("FAIL rnd_timing[%0d]: got req %0d stall %0d expected %0d %0d", i, reqc, stallc, delay + 1, delay); end
      n_checks++; if (wb_bad !== 0 || WBW !== wb) begin n_fail++; $display("FAIL rnd_wb[%0d]: got bad %0d WBW %b expected 0 %b", i, wb_bad, WBW, wb); end
      n_checks++; if (be0 !== model_be(bop, a) || we0 !== ~rd) begin n_fail++; $display("FAIL rnd_be[%0d]: got %h %b expected %h %b", i, be0, we0, model_be(bop, a), ~rd); end
      n_checks++; if (addr0 !== a || ResultW !== a) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h %h expected %h", i, addr0, ResultW, a); end
      if (rd) begin
        n_checks++; if (ReadDataW !== model_load(bop, a, d)) begin n_fail++; $display("FAIL rnd_load[%0d]: got %h expected %h", i, ReadDataW, model_load(bop, a, d)); end
      end else begin
        n_checks++; if (wd0 !== model_wdata(bop, w)) begin n_fail++; $display("FAIL rnd_wdata[%0d]: got %h expected %h", i, wd0, model_wdata(bop, w)); end
      end
    end
  endtask

  task automatic test_ack_at_limit();
    int reqc, stallc, wb_bad; logic [3:0] be0; logic we0, done;
    logic [31:0] wd0, addr0, d; logic [4:0] wreg;
    d = $urandom;
    run_access(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, d, 2'b11, TIMEOUT,
               reqc, stallc, wb_bad, be0, we0, wd0, addr0, wreg, done);
    n_checks++; if (reqc !== TIMEOUT + 1 || stallc !== TIMEOUT) begin n_fail++; $display("FAIL limit_timing: got req %0d stall %0d expected %0d %0d", reqc, stallc, TIMEOUT + 1, TIMEOUT); end
    n_checks++; if (BusErr !== 1'b0) begin n_fail++; $display("FAIL limit_buserr: got %b expected 0", BusErr); end
    n_checks++; if (ReadDataW !== d || WBW !== 2'b11) begin n_fail++; $display("FAIL limit_data: got %h %b expected %h 11", ReadDataW, WBW, d); end
  endtask

  task automatic test_timeout();
    int reqc, stallc, wb_bad; logic [3:0] be0; logic we0, done;
    logic [31:0] wd0, addr0, d; logic [4:0] wreg;
    run_access(1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 32'h0, 2'b11, -1,
               reqc, stallc, wb_bad, be0, we0, wd0, addr0, wreg, done);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL timeout_abandon: got done %b expected 1", done); end
    n_checks++; if (reqc !== TIMEOUT + 1 || stallc !== TIMEOUT) begin n_fail++; $display("FAIL timeout_timing: got req %0d stall %0d expected %0d %0d", reqc, stallc, TIMEOUT + 1, TIMEOUT); end
    n_checks++; if (BusErr !== 1'b1 || WBW !== 2'b00 || wb_bad !== 0) begin n_fail++; $display("FAIL timeout_bubble: got BusErr %b WBW %b bad %0d expected 1 00 0", BusErr, WBW, wb_bad); end
    d = $urandom;
    run_access(1'b1, 1'b0, 1'b0, 32'h204, 32'h0, d, 2'b11, 0,
               reqc, stallc, wb_bad, be0, we0, wd0, addr0, wreg, done);
    n_checks++; if (ReadDataW !== d || WBW !== 2'b11 || stallc !== 0) begin n_fail++; $display("FAIL timeout_next: got %h %b stall %0d expected %h 11 0", ReadDataW, WBW, stallc, d); end
    n_checks++; if (BusErr !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b expected 1", BusErr); end
  endtask

  task automatic test_misaligned();
    int reqc, stallc, wb_bad; logic [3:0] be0; logic we0, done;
    logic [31:0] wd0, addr0; logic [4:0] wreg;
    run_access(1'b1, 1'b0, 1'b0, 32'h42, 32'h0, 32'h12345678, 2'b11, 0,
               reqc, stallc, wb_bad, be0, we0, wd0, addr0, wreg, done);
    n_checks++; if (reqc !== 0 || stallc !== 0) begin n_fail++; $display("FAIL align_noreq: got req %0d stall %0d expected 0 0", reqc, stallc); end
    n_checks++; if (AlignErr !== 1'b1 || WBW !== 2'b00) begin n_fail++; $display("FAIL align_pulse: got AlignErr %b WBW %b expected 1 00", AlignErr, WBW); end
    step();
    n_checks++; if (AlignErr !== 1'b0) begin n_fail++; $display("FAIL align_once: got %b expected 0", AlignErr); end
  endtask

  task automatic test_io();
    logic [31:0] v, r;
    int pulses;
    v = 32'h5; pulses = 0;
    for (int i = 0; i < 2; i++) begin
      IOInstReg = 1'b1; MEMReg = 4'b0010; OutBReg = v; WBReg = 2'b00;
      @(negedge clk);
      n_checks++; if (dmem_req !== 1'b0 || MemStall !== 1'b0) begin n_fail++; $display("FAIL io_nostall[%0d]: got req %b stall %b expected 0 0", i, dmem_req, MemStall); end
      step(); nop();
      n_checks++; if (io_out !== v) begin n_fail++; $display("FAIL io_out[%0d]: got %h expected %h", i, io_out, v); end
      for (int k = 0; k < 3; k++) begin
        if (io_wr === 1'b1) pulses++;
        step();
      end
      n_checks++; if (pulses !== i + 1) begin n_fail++; $display("FAIL io_wr_pulses[%0d]: got %0d expected %0d", i, pulses, i + 1); end
      v = $urandom;
    end
    for (int i = 0; i < 2; i++) begin
      r = (i == 0) ? 32'h77 : $urandom;
      io_in = r; IOInstReg = 1'b1; MEMReg = 4'b0100; WBReg = 2'b11;
      step(); nop();
      n_checks++; if (ReadDataW !== r || WBW !== 2'b11 || io_wr !== 1'b0) begin n_fail++; $display("FAIL io_read[%0d]: got %h %b wr %b expected %h 11 0", i, ReadDataW, WBW, io_wr, r); end
    end
  endtask

  task automatic test_branch();
    logic [31:0] t;
    for (int i = 0; i < 3; i++) begin
      t = $urandom;
      MEMReg = 4'b1000; PCPlus4PlusOffReg = t; EqualReg = 1'b1;
      #1;
      n_checks++; if (PCSrc !== 1'b1 || BranchTarget !== t) begin n_fail++; $display("FAIL branch_taken[%0d]: got %b %h expected 1 %h", i, PCSrc, BranchTarget, t); end
      EqualReg = 1'b0;
      #1;
      n_checks++; if (PCSrc !== 1'b0) begin n_fail++; $display("FAIL branch_not_taken[%0d]: got %b expected 0", i, PCSrc); end
      step();
    end
    nop();
  endtask

  task automatic test_reset_mid_wait();
    nop();
    MEMReg = 4'b0100; ResultReg = 32'h80; WBReg = 2'b11; dmem_ack = 1'b0;
    repeat (3) step();
    @(negedge clk);
    n_checks++; if (dmem_req !== 1'b1 || MemStall !== 1'b1 || BusErr !== 1'b1) begin n_fail++; $display("FAIL rstwait_pre: got req %b stall %b buserr %b expected 1 1 1", dmem_req, MemStall, BusErr); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (dmem_req !== 1'b0 || MemStall !== 1'b0) begin n_fail++; $display("FAIL rstwait_req: got req %b stall %b expected 0 0", dmem_req, MemStall); end
    n_checks++; if ({Halted, BusErr, AlignErr} !== 3'b000 || WBW !== 2'b00) begin n_fail++; $display("FAIL rstwait_flags: got %b WBW %b expected 000 00", {Halted, BusErr, AlignErr}, WBW); end
    nop(); dmem_ack = 1'b1;
    @(negedge clk); reset = 1'b1;
    step();
    @(negedge clk);
    n_checks++; if (dmem_req !== 1'b0 || MemStall !== 1'b0 || WBW !== 2'b00 || BusErr !== 1'b0) begin n_fail++; $display("FAIL rstwait_late_ack: got req %b stall %b WBW %b buserr %b expected 0 0 00 0", dmem_req, MemStall, WBW, BusErr); end
    dmem_ack = 1'b0;
    step();
  endtask

  task automatic test_halt();
    logic [31:0] r;
    r = $urandom;
    nop(); HaltReg = 1'b1; WBReg = 2'b10; ResultReg = r; WrRegReg = 5'd7;
    step();
    n_checks++; if (Halted !== 1'b1 || MemStall !== 1'b1) begin n_fail++; $display("FAIL halt_entry: got %b %b expected 1 1", Halted, MemStall); end
    n_checks++; if (WBW !== 2'b10 || ResultW !== r || WrRegW !== 5'd7) begin n_fail++; $display("FAIL halt_capture: got %b %h r%0d expected 10 %h r7", WBW, ResultW, WrRegW, r); end
    nop(); MEMReg = 4'b1100; EqualReg = 1'b1; ResultReg = 32'h300; WBReg = 2'b11;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (Halted !== 1'b1 || MemStall !== 1'b1 || dmem_req !== 1'b0 || PCSrc !== 1'b0 || WBW !== 2'b00) begin n_fail++; $display("FAIL halt_hold[%0d]: got H%b S%b R%b P%b WBW %b expected 1 1 0 0 00", i, Halted, MemStall, dmem_req, PCSrc, WBW); end
    end
    nop(); reset = 1'b0;
    #1;
    n_checks++; if (Halted !== 1'b0 || MemStall !== 1'b0) begin n_fail++; $display("FAIL halt_exit: got %b %b expected 0 0", Halted, MemStall); end
    @(negedge clk); reset = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_byte_load();
    test_random_traffic();
    test_ack_at_limit();
    test_timeout();
    test_misaligned();
    test_io();
    test_branch();
    test_reset_mid_wait();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
